mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single-cycle core's instruction fetch and load/store traffic onto one shared single-port memory bus with a req/ack handshake.
- Sits between the core's fetch/data memory signals and the memory.
- Generates the core's stall_mem so that each instruction commits in exactly one unstalled cycle.
- Performs byte-lane steering for sub-word stores and right-alignment of load data; the core does its own sign extension.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
TIMEOUT, 64, max cycles bus_req may wait for bus_ack before abort (1..255)
NOP_INSTR, 32'h00000013, instruction word presented on reset and on fetch abort

Ports:
CLK  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
nextPC  in  32  core's next fetch address, sampled on commit cycles
memory_en  in  1  core's current instruction uses data memory
store_size  in  2  00 byte store, 01 half store, 10 word store, 11 load
mem_addr  in  32  core data byte address
mem_write_data  in  32  core store data, zero-extended in low bits
instr_fetch  out  32  registered instruction to core decoder
mem_read_data  out  32  registered load word, right-aligned to byte 0
stall_mem  out  1  1 = core holds PC and suppresses register write
bus_req  out  1  memory request
bus_we  out  1  1 = write
bus_be  out  4  byte enables, bit i = byte lane i
bus_addr  out  32  word address, bits[1:0] = 0
bus_wdata  out  32  lane-steered write data
bus_rdata  in  32  memory read data, valid with bus_ack
bus_ack  in  1  memory completion, single-cycle pulse
bus_err  out  1  sticky: a bus timeout occurred
misalign_err  out  1  sticky misaligned-access flag (see Optional Feature)

Behaviour:
Reset (reset=0, async):
- state=FETCH, fetch_addr=RESET_PC, instr_fetch=NOP_INSTR, mem_read_data=0.
- stall_mem=1, bus_req=0, bus_err=0, misalign_err=0, timeout counter=0.
- Deassertion takes effect at the next rising edge; FETCH issues its request then.

States:
- FETCH:
  - bus_req=1, bus_we=0, bus_be=4'hF, bus_addr={fetch_addr[31:2],2'b00}, stall_mem=1.
  - On bus_ack: instr_fetch<=bus_rdata, go to EXEC.
- EXEC:
  - bus_req=0.
  - If memory_en=0: stall_mem=0 (commit cycle), fetch_addr<=nextPC, go to FETCH.
  - Else: stall_mem=1, go to DATA.
- DATA:
  - bus_req=1, bus_addr={mem_addr[31:2],2'b00}, bus_we=(store_size!=11), stall_mem=1.
  - Byte store: bus_be=1<<a and bus_wdata=byte replicated on all 4 lanes, where a=mem_addr[1:0].
  - Half store: bus_be=4'b0011<<{a[1],1'b0}, half replicated on both halves.
  - Word store: bus_be=4'hF, data unchanged.
  - Load: bus_be=4'hF.
  - On bus_ack: for loads mem_read_data<=bus_rdata>>(8*a); stores leave mem_read_data unchanged. Go to COMMIT.
- COMMIT:
  - stall_mem=0, bus_req=0, fetch_addr<=nextPC, go to FETCH.

Handshake:
- bus_addr, bus_we, bus_be and bus_wdata are stable while bus_req=1, until the bus_ack cycle inclusive.
- bus_ack is allowed in the same cycle bus_req rises (zero wait).
- bus_req is low for at least 1 cycle between transactions.
- bus_ack while bus_req=0 is ignored.

Latency:
- Non-memory instruction: 2 cycles + fetch wait states.
- Load/store: 4 cycles + wait states.

Timeout:
- The counter is cleared on entry to FETCH/DATA and increments each cycle bus_req=1 && bus_ack=0.
- When it reaches TIMEOUT: drop bus_req, set bus_err=1.
  - In FETCH: instr_fetch<=NOP_INSTR, go to EXEC.
  - In DATA: mem_read_data<=0, go to COMMIT.
- A store aborted by timeout is not retried.

Reset mid-transaction: bus_req drops immediately (async); any in-flight ack after reset is ignored.

Optional Feature:
Macro MEM_MISALIGN_CHECK_EN.
- Defined: in EXEC with memory_en=1, a half access with a[0]=1 or a word access with a!=0 is misaligned.
  - Skip DATA, go directly to COMMIT; no bus transaction.
  - mem_read_data<=0, misalign_err set (sticky until reset).
- Undefined: no check; misalign_err tied 0.
  - Word accesses use the aligned word.
  - Half at a=3 uses lanes 2-3 (a[0] ignored).

Test Plan:
- Reset release, RESET_PC=0, memory returns 32'h00500093 with 0 wait states → bus_addr=0, instr_fetch=32'h00500093 next cycle, stall_mem=0 for exactly 1 cycle, next fetch bus_addr=nextPC=4.
- LW at mem_addr=0x100, bus_rdata=32'hDEADBEEF after 3 wait states → bus_we=0, bus_be=F, mem_read_data=32'hDEADBEEF in COMMIT, stall_mem high for 5 cycles before COMMIT.
- SB store_size=00, mem_addr=0x203, mem_write_data=32'h000000A5 → bus_addr=0x200, bus_be=4'b1000, bus_wdata=32'hA5A5A5A5, bus_we=1.
- LBU at mem_addr=0x102, bus_rdata=32'h11223344 → mem_read_data=32'h00001122.
- bus_ack never returned in FETCH, TIMEOUT=64 → bus_req drops after 64 cycles, bus_err=1, instr_fetch=32'h00000013, core commits NOP.
- With MEM_MISALIGN_CHECK_EN, SW at mem_addr=0x102 → no bus_req after EXEC, misalign_err=1, COMMIT follows EXEC directly; without the macro → bus_addr=0x100, bus_be=F.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and load/store, stalling the core.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word stores skip the bus and raise misalign_err.
module mem_port_arbiter #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] nextPC,
    input  logic        memory_en,
    input  logic [1:0]  store_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] instr_fetch,
    output logic [31:0] mem_read_data,
    output logic        stall_mem,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output logic        misalign_err
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_DATA, S_COMMIT} state_t;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_fetch_addr;
    logic [7:0]  r_cnt;
    logic [1:0]  r_a;
    logic        r_req;
    logic        r_we;
    logic [3:0]  r_be;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_instr;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_commit;
    logic        w_fetch_go;
    logic [31:0] w_pc_next;
    logic        w_unused;

    // Sub-word stores replicate their data on every lane; byte enables pick the live one.
    always_comb begin
        w_be    = 4'hF;
        w_wdata = mem_write_data;
        case (store_size)
            2'b00: begin
                w_be    = 4'b0001 << mem_addr[1:0];
                w_wdata = {4{mem_write_data[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {mem_addr[1], 1'b0};
                w_wdata = {2{mem_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_commit   = (r_state == S_EXEC && !memory_en) || r_state == S_COMMIT;
    // The first fetch after reset launches from FETCH itself; later ones launch on commit.
    assign w_fetch_go = w_commit || (r_state == S_FETCH && !r_req);
    assign w_pc_next  = (r_state == S_FETCH) ? r_fetch_addr : nextPC;
    assign w_unused   = ^w_pc_next[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    logic w_mis;
    logic r_mis;
    assign w_mis = (store_size == 2'b01 && mem_addr[0]) ||
                   (store_size == 2'b10 && mem_addr[1:0] != 2'b00);
    assign misalign_err = r_mis;
`else
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_fetch_addr <= RESET_PC;
            r_cnt        <= 8'd0;
            r_a          <= 2'd0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= 4'hF;
            r_addr       <= 30'd0;
            r_wdata      <= 32'd0;
            r_instr      <= NOP_INSTR;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            r_mis        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: if (r_req) begin
                    if (bus_ack) begin
                        r_instr <= bus_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_EXEC;
                    end else if (r_cnt == TMO_LAST) begin
                        r_instr <= NOP_INSTR;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (!memory_en) begin
                        r_fetch_addr <= nextPC;
                        r_state      <= S_FETCH;
                    end
`ifdef MEM_MISALIGN_CHECK_EN
                    else if (w_mis) begin
                        r_rdata <= 32'd0;
                        r_mis   <= 1'b1;
                        r_state <= S_COMMIT;
                    end
`endif
                    else begin
                        r_req   <= 1'b1;
                        r_we    <= (store_size != 2'b11);
                        r_be    <= w_be;
                        r_addr  <= mem_addr[31:2];
                        r_wdata <= w_wdata;
                        r_a     <= mem_addr[1:0];
                        r_cnt   <= 8'd0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus_ack) begin
                        if (!r_we) r_rdata <= bus_rdata >> {r_a, 3'b000};
                        r_req   <= 1'b0;
                        r_state <= S_COMMIT;
                    end else if (r_cnt == TMO_LAST) begin
                        r_rdata <= 32'd0;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_COMMIT: begin
                    r_fetch_addr <= nextPC;
                    r_state      <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
            if (w_fetch_go) begin
                r_req  <= 1'b1;
                r_we   <= 1'b0;
                r_be   <= 4'hF;
                r_addr <= w_pc_next[31:2];
                r_cnt  <= 8'd0;
            end
        end
    end

    assign instr_fetch   = r_instr;
    assign mem_read_data = r_rdata;
    assign stall_mem     = !w_commit;
    assign bus_req       = r_req;
    assign bus_we        = r_we;
    assign bus_be        = r_be;
    assign bus_addr      = {r_addr, 2'b00};
    assign bus_wdata     = r_wdata;
    assign bus_err       = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: acts as both core and memory, directed table plus random instructions.
module tb_mem_port_arbiter;
    localparam int          TMO = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] nextPC;
    logic        memory_en;
    logic [1:0]  store_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] instr_fetch;
    logic [31:0] mem_read_data;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        misalign_err;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.RESET_PC(32'h0), .TIMEOUT(TMO), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .reset(reset), .nextPC(nextPC), .memory_en(memory_en),
        .store_size(store_size), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .instr_fetch(instr_fetch), .mem_read_data(mem_read_data), .stall_mem(stall_mem),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    typedef struct {
        logic        mem_en;
        logic [1:0]  ss;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] instr;
        logic [31:0] rdata;
        int          fwait;
        int          dwait;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_rd;
    vec_t        tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic me, input logic [1:0] ss, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] instr,
                                input logic [31:0] rdata, input int fw, input int dw,
                                input logic mis, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] rd);
        vec_t v;
        v.mem_en = me; v.ss = ss; v.addr = addr; v.wd = wd; v.instr = instr;
        v.rdata = rdata; v.fwait = fw; v.dwait = dw; v.mis = mis; v.be = be;
        v.wdata = wdata; v.rd = rd;
        return v;
    endfunction

    // Reference rules, stated arithmetically from the lane definitions.
    function automatic logic m_mis(input logic [1:0] ss, input int a);
`ifdef MEM_MISALIGN_CHECK_EN
        return (ss == 2'd1 && a % 2 == 1) || (ss == 2'd2 && a != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] ss, input int a);
        if (ss == 2'd0) return 4'(2 ** a);
        if (ss == 2'd1) return (a >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] ss, input logic [31:0] wd);
        if (ss == 2'd0) return (wd % 256) * 32'h0101_0101;
        if (ss == 2'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input int a);
        longint q;
        q = longint'(rdata) / (longint'(1) << (8 * a));
        return 32'(q);
    endfunction

    // Runs one instruction, starting at a negedge while the DUT is in (or entering) FETCH.
    task automatic run(input vec_t v, input logic [31:0] npc);
        int          k;
        int          stall_n;
        logic [31:0] fa;
        logic [31:0] da;
        memory_en = v.mem_en; store_size = v.ss; mem_addr = v.addr;
        mem_write_data = v.wd; nextPC = npc;
        fa = exp_pc - (exp_pc % 4);
        da = v.addr - (v.addr % 4);
        k = 0;
        while (!bus_req && k < 4) begin @(negedge CLK); k++; end
        chk("fetch_req", {31'd0, bus_req}, 32'd1);
        if (!bus_req) return;
        chk("fetch_addr", bus_addr, fa);
        chk("fetch_we_be", {27'd0, bus_we, bus_be}, 32'h0F);
        chk("fetch_stall", {31'd0, stall_mem}, 32'd1);
        for (int i = 0; i < v.fwait; i++) begin
            @(negedge CLK);
            chk("fetch_hold", {bus_req, bus_addr[30:0]}, {1'b1, fa[30:0]});
        end
        bus_ack = 1'b1; bus_rdata = v.instr;
        @(negedge CLK);
        bus_ack = 1'b0; bus_rdata = $urandom;
        chk("instr_fetch", instr_fetch, v.instr);
        chk("exec_req", {31'd0, bus_req}, 32'd0);
        if (!v.mem_en) begin
            chk("exec_commit_stall", {31'd0, stall_mem}, 32'd0);
            exp_pc = npc;
            @(negedge CLK);
            chk("post_commit_stall", {31'd0, stall_mem}, 32'd1);
            return;
        end
        stall_n = stall_mem ? 1 : 0;
        @(negedge CLK);
        if (v.mis) begin
            chk("mis_req", {31'd0, bus_req}, 32'd0);
            chk("mis_err", {31'd0, misalign_err}, 32'd1);
        end else begin
            chk("data_req", {31'd0, bus_req}, 32'd1);
            chk("data_addr", bus_addr, da);
            chk("data_we", {31'd0, bus_we}, {31'd0, v.ss != 2'd3});
            chk("data_be", {28'd0, bus_be}, {28'd0, v.be});
            if (v.ss != 2'd3) chk("data_wdata", bus_wdata, v.wdata);
            for (int i = 0; i < v.dwait; i++) begin
                if (stall_mem) stall_n++;
                @(negedge CLK);
                chk("data_hold", {bus_req, bus_be, bus_addr[26:0]}, {1'b1, v.be, da[26:0]});
            end
            if (stall_mem) stall_n++;
            bus_ack = 1'b1; bus_rdata = v.rdata;
            @(negedge CLK);
            bus_ack = 1'b0; bus_rdata = $urandom;
            chk("commit_req", {31'd0, bus_req}, 32'd0);
        end
        chk("commit_stall", {31'd0, stall_mem}, 32'd0);
        chk("stall_cycles", 32'(stall_n), v.mis ? 32'd1 : 32'(v.dwait + 2));
        chk("mem_read_data", mem_read_data, v.rd);
        exp_rd = v.rd;
        exp_pc = npc;
        @(negedge CLK);
        chk("post_commit_stall", {31'd0, stall_mem}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   a;
        int   k;
        reset = 1'b0; nextPC = 0; memory_en = 0; store_size = 2'd3; mem_addr = 0;
        mem_write_data = 0; bus_rdata = 0; bus_ack = 0;
        exp_pc = 32'h0; exp_rd = 32'h0;

        tbl[0] = mk(0, 2'd3, 0, 0, 32'h00500093, 0, 0, 0, 0, 4'hF, 0, 0);
        tbl[1] = mk(1, 2'd3, 32'h100, 0, 32'h00002003, 32'hDEADBEEF, 0, 3, 0, 4'hF, 0, 32'hDEADBEEF);
        tbl[2] = mk(1, 2'd0, 32'h203, 32'hA5, 32'h1, 0, 1, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'hDEADBEEF);
        tbl[3] = mk(1, 2'd3, 32'h102, 0, 32'h2, 32'h11223344, 0, 0, 0, 4'hF, 0, 32'h00001122);
        tbl[4] = mk(1, 2'd1, 32'h002, 32'hBEEF, 32'h3, 0, 0, 1, 0, 4'b1100, 32'hBEEFBEEF, 32'h00001122);
`ifdef MEM_MISALIGN_CHECK_EN
        tbl[5] = mk(1, 2'd2, 32'h102, 32'h12345678, 32'h4, 0, 0, 0, 1, 4'hF, 0, 32'h0);
`else
        tbl[5] = mk(1, 2'd2, 32'h102, 32'h12345678, 32'h4, 0, 0, 0, 0, 4'hF, 32'h12345678, 32'h00001122);
`endif
        tbl[6] = mk(1, 2'd3, 32'h104, 0, 32'h5, 32'hCAFEF00D, 2, 2, 0, 4'hF, 0, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_CHECK_EN
        tbl[7] = mk(1, 2'd1, 32'h003, 32'hABCD, 32'h6, 0, 0, 0, 1, 4'hF, 0, 32'h0);
`else
        tbl[7] = mk(1, 2'd1, 32'h003, 32'hABCD, 32'h6, 0, 0, 0, 0, 4'b1100, 32'hABCDABCD, 32'hCAFEF00D);
`endif
        tbl[8] = mk(1, 2'd3, 32'h106, 0, 32'h7, 32'hAABBCCDD, 1, 1, 0, 4'hF, 0, 32'h0000AABB);
        tbl[9] = mk(1, 2'd0, 32'h000, 32'h7F, 32'h8, 0, 0, 0, 0, 4'b0001, 32'h7F7F7F7F, 32'h0000AABB);
        tbl[10] = mk(0, 2'd3, 0, 0, 32'h00100113, 0, 3, 0, 0, 4'hF, 0, 0);

        repeat (2) @(negedge CLK);
        chk("rst_instr", instr_fetch, NOP);
        chk("rst_rdata", mem_read_data, 32'h0);
        chk("rst_ctl", {27'd0, stall_mem, bus_req, bus_err, misalign_err, 1'b0}, 32'h10);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run(tbl[i], exp_pc + 32'd4);

        for (int n = 0; n < 60; n++) begin
            v.mem_en = 1'($urandom_range(0, 1));
            v.ss     = 2'($urandom_range(0, 3));
            v.addr   = $urandom;
            a        = int'(v.addr % 4);
            v.wd     = $urandom;
            if (v.ss == 2'd0) v.wd = v.wd % 256;
            if (v.ss == 2'd1) v.wd = v.wd % 65536;
            v.instr  = $urandom;
            v.rdata  = $urandom;
            v.fwait  = $urandom_range(0, 3);
            v.dwait  = $urandom_range(0, 3);
            v.mis    = (v.ss != 2'd3) && m_mis(v.ss, a);
            v.be     = m_be(v.ss, a);
            v.wdata  = m_wdata(v.ss, v.wd);
            if (v.mis) v.rd = 32'h0;
            else if (v.ss == 2'd3) v.rd = m_load(v.rdata, a);
            else v.rd = exp_rd;
            run(v, $urandom);
        end

`ifdef MEM_MISALIGN_CHECK_EN
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
`else
        chk("misalign_tied", {31'd0, misalign_err}, 32'd0);
`endif
        chk("no_err_yet", {31'd0, bus_err}, 32'd0);

        // Fetch that is never acknowledged must abort into a NOP.
        memory_en = 1'b0; nextPC = exp_pc + 32'd8;
        k = 0;
        while (bus_req && k < 200) begin @(negedge CLK); k++; end
        chk("timeout_cycles", 32'(k), 32'(TMO));
        chk("timeout_err", {31'd0, bus_err}, 32'd1);
        chk("timeout_nop", instr_fetch, NOP);
        chk("timeout_commit", {31'd0, stall_mem}, 32'd0);
        exp_pc = nextPC;
        @(negedge CLK);
        chk("after_tmo_addr", bus_addr, exp_pc - (exp_pc % 4));
        chk("after_tmo_req", {31'd0, bus_req}, 32'd1);

        // Reset in the middle of a request, with a stray ack around release.
        #2 reset = 1'b0; bus_ack = 1'b1;
        #1 chk("async_req_drop", {31'd0, bus_req}, 32'd0);
        chk("rst_err_clear", {30'd0, bus_err, misalign_err}, 32'd0);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        bus_ack = 1'b0;
        chk("rst_refetch_req", {31'd0, bus_req}, 32'd1);
        chk("rst_refetch_addr", bus_addr, 32'h0);
        chk("rst_instr_kept", instr_fetch, NOP);
        exp_pc = 32'h0; exp_rd = 32'h0;
        run(tbl[0], 32'h4);
        run(tbl[1], 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
